// File: rtl/mips_cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_cpu_pkg
// Purpose  : Shared fetch FSM state type, default addresses and helpers.
// Revision : 1.0
// ============================================================================
package mips_cpu_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2,
        S_HALT = 2'd3
    } fetch_state_t;

    localparam logic [31:0] FETCH_RESET_VECTOR = 32'hBFC0_0000;
    localparam logic [31:0] FETCH_HALT_ADDR    = 32'h0000_0000;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/mips_cpu_next_pc.sv
`default_nettype none
// ============================================================================
// Module   : mips_cpu_next_pc
// Purpose  : Selects the PC following the current fetch and flags a halt PC.
// Revision : 1.0
// ============================================================================
module mips_cpu_next_pc
    import mips_cpu_pkg::*;
#(
    parameter logic [31:0] HALT_ADDR = FETCH_HALT_ADDR
) (
    input  logic [31:0] i_pc,
    input  logic        i_pending,
    input  logic [31:0] i_pending_target,
    output logic [31:0] o_next_pc,
    output logic        o_is_halt
);

    // A pending redirect replaces the sequential successor of the delay slot.
    assign o_next_pc = i_pending ? i_pending_target : (i_pc + 32'd4);
    assign o_is_halt = (i_pc == HALT_ADDR);

endmodule
`default_nettype wire

// File: rtl/mips_cpu_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : mips_cpu_fetch_unit
// Purpose  : Instruction-fetch master with delay-slot redirect and halt detect.
// Revision : 1.0
// ============================================================================
module mips_cpu_fetch_unit
    import mips_cpu_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = FETCH_RESET_VECTOR,
    parameter logic [31:0] HALT_ADDR    = FETCH_HALT_ADDR
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] mem_address,
    output logic        mem_read,
    input  logic        mem_waitrequest,
    input  logic [31:0] mem_readdata,
    output logic [31:0] instr_word,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        active
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  word_q, word_d;
    logic [31:0]  ipc_q, ipc_d;
    logic         pending_q, pending_d;
    logic [31:0]  pending_target_q, pending_target_d;

    logic [31:0]  w_next_pc;
    logic         w_is_halt;

    mips_cpu_next_pc #(
        .HALT_ADDR (HALT_ADDR)
    ) u_next_pc (
        .i_pc             (pc_q),
        .i_pending        (pending_q),
        .i_pending_target (pending_target_q),
        .o_next_pc        (w_next_pc),
        .o_is_halt        (w_is_halt)
    );

    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        word_d           = word_q;
        ipc_d            = ipc_q;
        pending_d        = pending_q;
        pending_target_d = pending_target_q;
        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (!mem_waitrequest) begin
                    word_d  = mem_readdata;
                    ipc_d   = pc_q;
                    pc_d    = w_next_pc;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (instr_ready) begin
                    state_d = w_is_halt ? S_HALT : S_REQ;
                    // Pending stays set until the delay slot itself is consumed,
                    // so a branch sitting in the slot cannot override the first.
                    if (pending_q) begin
                        pending_d = 1'b0;
                    end else if (redirect_valid) begin
                        pending_d        = 1'b1;
                        pending_target_d = word_align(redirect_target);
                    end
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= S_IDLE;
            pc_q             <= RESET_VECTOR;
            word_q           <= 32'd0;
            ipc_q            <= 32'd0;
            pending_q        <= 1'b0;
            pending_target_q <= 32'd0;
        end else begin
            state_q          <= state_d;
            pc_q             <= pc_d;
            word_q           <= word_d;
            ipc_q            <= ipc_d;
            pending_q        <= pending_d;
            pending_target_q <= pending_target_d;
        end
    end

    assign mem_address = word_align(pc_q);
    assign mem_read    = (state_q == S_REQ);
    assign instr_valid = (state_q == S_HOLD);
    assign active      = (state_q == S_REQ) || (state_q == S_HOLD);
    assign instr_word  = word_q;
    assign instr_pc    = ipc_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_cpu_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_cpu_fetch_unit
// Purpose  : Self-checking bench: vector table, corner sequences, random model.
// Revision : 1.0
// ============================================================================
module tb_mips_cpu_fetch_unit;

    localparam logic [31:0] RV   = 32'hBFC0_0000;
    localparam logic [31:0] HALT = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_waitrequest = 1'b0;
    logic [31:0] mem_readdata;
    logic [31:0] instr_word;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'd0;
    logic        active;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    assign mem_readdata = memf(mem_address);

    mips_cpu_fetch_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .mem_address     (mem_address),
        .mem_read        (mem_read),
        .mem_waitrequest (mem_waitrequest),
        .mem_readdata    (mem_readdata),
        .instr_word      (instr_word),
        .instr_pc        (instr_pc),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .active          (active)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Leaves rst_n released at a falling edge; the DUT is then in its idle cycle.
    task automatic do_reset();
        rst_n           = 1'b0;
        mem_waitrequest = 1'b0;
        instr_ready     = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst_read", {31'd0, mem_read}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_active", {31'd0, active}, 32'd0);
        chk("rst_addr", mem_address, RV);
        rst_n = 1'b1;
    endtask

    // Waits (bounded) for the next delivered word, checks it and consumes it.
    task automatic consume_next(input logic [31:0] exp_pc, input bit redir, input logic [31:0] tgt);
        int n;
        n = 0;
        mem_waitrequest = 1'b0;
        instr_ready     = 1'b1;
        redirect_valid  = 1'b0;
        while (!instr_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!instr_valid) begin
            chk("consume_timeout", {31'd0, instr_valid}, 32'd1);
        end else begin
            chk("seq_pc", instr_pc, exp_pc);
            chk("seq_word", instr_word, memf(exp_pc));
            redirect_valid  = redir;
            redirect_target = tgt;
            @(negedge clk);
            redirect_valid  = 1'b0;
        end
    endtask

    task automatic expect_halted(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            chk("halt_active", {31'd0, active}, 32'd0);
            chk("halt_read", {31'd0, mem_read}, 32'd0);
            chk("halt_valid", {31'd0, instr_valid}, 32'd0);
            @(negedge clk);
        end
    endtask

    typedef struct {
        bit          wr;
        bit          rdy;
        bit          rv;
        logic [31:0] tgt;
        bit          e_read;
        logic [31:0] e_addr;
        bit          e_valid;
        logic [31:0] e_pc;
        bit          e_active;
    } vec_t;

    function automatic vec_t mk(bit wr, bit rdy, bit rv, logic [31:0] tgt, bit er,
                                logic [31:0] ea, bit ev, logic [31:0] ep, bit eact);
        vec_t v;
        v.wr = wr; v.rdy = rdy; v.rv = rv; v.tgt = tgt;
        v.e_read = er; v.e_addr = ea; v.e_valid = ev; v.e_pc = ep; v.e_active = eact;
        return v;
    endfunction

    task automatic random_run(input int ncyc);
        logic [31:0] q[$];
        logic [31:0] e, pa, pp, pw;
        bit          slot, halted, prev_rw, prev_hold;
        int          hcnt, idle, sel;
        do_reset();
        q = {RV}; slot = 0; halted = 0; hcnt = 0; idle = 0;
        prev_rw = 0; prev_hold = 0; pa = 0; pp = 0; pw = 0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (prev_rw) begin
                chk("rnd_read_held", {31'd0, mem_read}, 32'd1);
                chk("rnd_addr_held", mem_address, pa);
            end
            if (prev_hold) begin
                chk("rnd_valid_held", {31'd0, instr_valid}, 32'd1);
                chk("rnd_pc_held", instr_pc, pp);
                chk("rnd_word_held", instr_word, pw);
            end
            prev_rw = 0;
            prev_hold = 0;
            if (halted) begin
                chk("rnd_halt_active", {31'd0, active}, 32'd0);
                chk("rnd_halt_read", {31'd0, mem_read}, 32'd0);
                hcnt++;
                if (hcnt >= 3) begin
                    do_reset();
                    q = {RV}; slot = 0; halted = 0; hcnt = 0; idle = 0;
                end
                continue;
            end
            chk("rnd_active", {31'd0, active}, 32'd1);
            idle++;
            if (idle > 60) begin
                chk("rnd_no_progress_cycles", idle, 32'd60);
                do_reset();
                q = {RV}; slot = 0; idle = 0;
                continue;
            end
            mem_waitrequest = ($urandom_range(0, 2) == 0);
            instr_ready     = ($urandom_range(0, 2) != 0);
            redirect_valid  = ($urandom_range(0, 3) == 0);
            sel = $urandom_range(0, 19);
            if (sel == 0)
                redirect_target = 32'h0000_0002;
            else if (sel == 1)
                redirect_target = 32'hFFFF_FFF4 | $urandom_range(0, 3);
            else
                redirect_target = RV + ($urandom_range(0, 1023) * 4) + $urandom_range(0, 3);
            if (mem_read && !mem_waitrequest)
                chk("rnd_fetch_addr", mem_address, q[0]);
            if (instr_valid && instr_ready) begin
                chk("rnd_pc", instr_pc, q[0]);
                chk("rnd_word", instr_word, memf(q[0]));
                e = q.pop_front();
                idle = 0;
                if (slot) begin
                    slot = 0;
                end else if (redirect_valid) begin
                    q.push_back(e + 32'd4);
                    q.push_back(redirect_target & ~32'h3);
                    slot = 1;
                end
                if (q.size() == 0) q.push_back(e + 32'd4);
                if (q[0] == HALT) halted = 1;
            end
            prev_rw   = mem_read && mem_waitrequest;
            pa        = mem_address;
            prev_hold = instr_valid && !instr_ready;
            pp        = instr_pc;
            pw        = instr_word;
        end
    endtask

    vec_t tbl[22];

    initial begin
        // Per-cycle vectors: outputs checked at the falling edge, then inputs applied.
        tbl[0]  = mk(0, 1, 0, 32'h0,          0, RV,          0, 32'h0,       0);
        tbl[1]  = mk(0, 1, 0, 32'h0,          1, RV,          0, 32'h0,       1);
        tbl[2]  = mk(0, 1, 0, 32'h0,          0, RV + 32'h4,  1, RV,          1);
        tbl[3]  = mk(0, 1, 0, 32'h0,          1, RV + 32'h4,  0, 32'h0,       1);
        tbl[4]  = mk(0, 1, 0, 32'h0,          0, RV + 32'h8,  1, RV + 32'h4,  1);
        tbl[5]  = mk(0, 1, 0, 32'h0,          1, RV + 32'h8,  0, 32'h0,       1);
        tbl[6]  = mk(0, 1, 1, 32'hBFC0_0101,  0, RV + 32'hC,  1, RV + 32'h8,  1);
        tbl[7]  = mk(0, 1, 0, 32'h0,          1, RV + 32'hC,  0, 32'h0,       1);
        tbl[8]  = mk(0, 1, 1, 32'hBFC0_0200,  0, RV + 32'h100, 1, RV + 32'hC, 1);
        tbl[9]  = mk(0, 1, 0, 32'h0,          1, RV + 32'h100, 0, 32'h0,      1);
        tbl[10] = mk(0, 1, 0, 32'h0,          0, RV + 32'h104, 1, RV + 32'h100, 1);
        tbl[11] = mk(1, 1, 0, 32'h0,          1, RV + 32'h104, 0, 32'h0,      1);
        tbl[12] = mk(1, 1, 0, 32'h0,          1, RV + 32'h104, 0, 32'h0,      1);
        tbl[13] = mk(1, 1, 0, 32'h0,          1, RV + 32'h104, 0, 32'h0,      1);
        tbl[14] = mk(0, 0, 0, 32'h0,          1, RV + 32'h104, 0, 32'h0,      1);
        tbl[15] = mk(0, 0, 1, 32'hBFC0_0400,  0, RV + 32'h108, 1, RV + 32'h104, 1);
        tbl[16] = mk(0, 0, 0, 32'h0,          0, RV + 32'h108, 1, RV + 32'h104, 1);
        tbl[17] = mk(0, 0, 0, 32'h0,          0, RV + 32'h108, 1, RV + 32'h104, 1);
        tbl[18] = mk(0, 1, 0, 32'h0,          0, RV + 32'h108, 1, RV + 32'h104, 1);
        tbl[19] = mk(0, 1, 0, 32'h0,          1, RV + 32'h108, 0, 32'h0,      1);
        tbl[20] = mk(0, 1, 0, 32'h0,          0, RV + 32'h10C, 1, RV + 32'h108, 1);
        tbl[21] = mk(0, 1, 0, 32'h0,          1, RV + 32'h10C, 0, 32'h0,      1);

        do_reset();
        for (int i = 0; i < 22; i++) begin
            if (i > 0) @(negedge clk);
            chk($sformatf("vec%0d_read", i), {31'd0, mem_read}, {31'd0, tbl[i].e_read});
            chk($sformatf("vec%0d_addr", i), mem_address, tbl[i].e_addr);
            chk($sformatf("vec%0d_valid", i), {31'd0, instr_valid}, {31'd0, tbl[i].e_valid});
            chk($sformatf("vec%0d_active", i), {31'd0, active}, {31'd0, tbl[i].e_active});
            if (tbl[i].e_valid) begin
                chk($sformatf("vec%0d_pc", i), instr_pc, tbl[i].e_pc);
                chk($sformatf("vec%0d_word", i), instr_word, memf(tbl[i].e_pc));
            end
            mem_waitrequest = tbl[i].wr;
            instr_ready     = tbl[i].rdy;
            redirect_valid  = tbl[i].rv;
            redirect_target = tbl[i].tgt;
        end

        // Jump to the halt address: the delay slot is still delivered.
        do_reset();
        consume_next(RV,          0, 32'h0);
        consume_next(RV + 32'h4,  0, 32'h0);
        consume_next(RV + 32'h8,  0, 32'h0);
        consume_next(RV + 32'hC,  0, 32'h0);
        consume_next(RV + 32'h10, 1, 32'h0000_0000);
        consume_next(RV + 32'h14, 0, 32'h0);
        expect_halted(5);

        // Sequential wrap past the top of the address space halts at zero.
        do_reset();
        consume_next(RV,           1, 32'hFFFF_FFFA);
        consume_next(RV + 32'h4,   0, 32'h0);
        consume_next(32'hFFFF_FFF8, 0, 32'h0);
        consume_next(32'hFFFF_FFFC, 0, 32'h0);
        expect_halted(3);

        // Reset during a stalled read with a redirect pending.
        do_reset();
        consume_next(RV, 1, 32'hBFC0_0300);
        mem_waitrequest = 1'b1;
        @(negedge clk);
        chk("midrst_read_before", {31'd0, mem_read}, 32'd1);
        chk("midrst_addr_before", mem_address, RV + 32'h4);
        rst_n = 1'b0;
        #1;
        chk("midrst_read_async", {31'd0, mem_read}, 32'd0);
        chk("midrst_active_async", {31'd0, active}, 32'd0);
        chk("midrst_addr_async", mem_address, RV);
        @(negedge clk);
        mem_waitrequest = 1'b0;
        rst_n = 1'b1;
        consume_next(RV,          0, 32'h0);
        consume_next(RV + 32'h4,  0, 32'h0);
        consume_next(RV + 32'h8,  0, 32'h0);

        random_run(3000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
